stream_to_3d_array_buffer: RTL and testbench
============================================

# stream_to_3d_array_buffer

Streaming successor to the flat-bus-to-3D-array converter. It assembles a ROWS×COLS frame of BIT_WIDTH-bit elements from a valid/ready stream carrying LANES elements per beat. It presents the finished frame as a registered 3D array with its own valid/ready handshake. It sits between a narrow upstream producer (memory reader, deserialiser) and array-consuming compute blocks that need a whole frame at once.

## Interface
- BIT_WIDTH, 4, element width in bits
- ROWS, 8, rows in output array
- COLS, 8, columns in output array
- LANES, 2, elements per input beat; ROWS*COLS must be an integer multiple of LANES, otherwise elaboration fails
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  LANES*BIT_WIDTH  lane l is in_data[l*BIT_WIDTH +: BIT_WIDTH]
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_last  input  1  marks final beat of a frame
- row_fast  input  1  element order for the frame; sampled on beat 0 only
- out  output  [BIT_WIDTH-1:0] [ROWS-1:0][COLS-1:0]  assembled frame, registered
- out_valid  output  1  frame in out is complete
- out_ready  input  1  frame consumed when out_valid && out_ready
- err  output  1  one-cycle pulse on framing error

## Operation
- BEATS = ROWS*COLS/LANES. A beat counter runs 0..BEATS-1 and wraps to 0 after the final beat. Element index e = beat*LANES + l.
- Order 1 (row_fast=1, legacy layout): element e goes to row e % ROWS, column e / ROWS.
- Order 0: element e goes to row e / COLS, column e % COLS.
- The order is latched on acceptance of beat 0 and applies to the whole frame. A change of row_fast mid-frame has no effect.
- Final beat without in_last: the frame completes normally and err pulses.
- in_last on a non-final beat: the beat is accepted and the frame is aborted. The counter returns to 0, nothing is presented, err pulses, and assembly storage keeps stale data.
- Frame presentation: out_valid rises and stays high, with out held stable, until the out_valid && out_ready handshake.
- States: FILL (accepting beats) and HOLD (frame presented).
  - FILL → HOLD on acceptance of the final beat.
  - HOLD → FILL on the output handshake.
  - In double-buffer builds the assembly path and the output register advance independently (see Configuration).

## Timing
- Reset values: out all zeros, out_valid 0, err 0, in_ready 1, beat counter 0, latched order 1.
- Reset asserted mid-frame discards the partial frame and any held frame immediately, asynchronously.
- Latency: out_valid is high in the cycle after the final beat is accepted.
- err is high for exactly the one cycle after the offending beat is accepted.
- in_ready is a registered/state function only, with no combinational path from out_ready or in_valid.
- Without the macro: in_ready = !out_valid. Frame period is at least BEATS+1 cycles.
- Handshake rule: in_valid and in_data must stay stable until accepted. out_valid is never withdrawn before the handshake.

## Configuration
- DOUBLE_BUFFER_EN defined: a separate assembly register feeds the output register.
  - A completed frame transfers to out in the cycle after its final beat, provided out_valid is 0 or the output handshake occurs in that same cycle.
  - Otherwise the frame waits in assembly and in_ready is 0 until the transfer.
  - Back-to-back frames with out_ready held at 1 run at one beat per cycle with no bubbles.
- DOUBLE_BUFFER_EN undefined: a single storage, the out register itself. Assembly stalls while a frame is held.

## Test plan
- Defaults, row_fast=1, beats carry element values e mod 16, out_ready=1 → out[i][j] == (j*8+i) mod 16. out_valid rises the cycle after beat 31, for one cycle.
- Same stream with row_fast=0 → out[i][j] == (i*8+j) mod 16. Toggling row_fast after beat 0 leaves the result unchanged.
- in_last on beat 5 → err pulses once, no out_valid. The next 32-beat frame presents correctly.
- Beat 31 without in_last → frame presented and err pulses in the same cycle as out_valid rises.
- Hold out_ready=0 for 50 cycles after a frame completes → out stable, out_valid stays 1. in_ready=0 without the macro; with DOUBLE_BUFFER_EN, in_ready=0 only after the second frame's 32 beats complete.
- rst_n low during beat 17 → all outputs return to reset values at once. The first full frame after release is correct.

Source files
------------

// File: rtl/stream_to_3d_array_buffer_if.sv
// Stream-in / frame-out handshake bundle for stream_to_3d_array_buffer.
// slave = the buffer itself, master = the producer/consumer environment.
interface stream_to_3d_array_buffer_if #(
    parameter int unsigned BIT_WIDTH = 4,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned LANES     = 2
);
    logic [LANES*BIT_WIDTH-1:0]               in_data;
    logic                                     in_valid;
    logic                                     in_ready;
    logic                                     in_last;
    logic                                     row_fast;
    logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] out;
    logic                                     out_valid;
    logic                                     out_ready;
    logic                                     err;

    modport master (
        output in_data, in_valid, in_last, row_fast, out_ready,
        input  in_ready, out, out_valid, err
    );

    modport slave (
        input  in_data, in_valid, in_last, row_fast, out_ready,
        output in_ready, out, out_valid, err
    );
endinterface

// File: rtl/stream_to_3d_array_buffer.sv
// Assembles a ROWS x COLS frame from a LANES-wide valid/ready stream and presents it registered.
// Define DOUBLE_BUFFER_EN for a separate assembly register so filling overlaps presentation.
module stream_to_3d_array_buffer #(
    parameter int unsigned BIT_WIDTH = 4,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned LANES     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    stream_to_3d_array_buffer_if.slave bus
);
    localparam int unsigned BEATS = (ROWS * COLS) / LANES;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned KW    = (COLS > 1) ? $clog2(COLS) : 1;

    typedef logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] frame_t;
    typedef enum logic {FILL, HOLD} state_t;

    if ((ROWS * COLS) % LANES != 0) begin : g_bad_lanes
        $error("ROWS*COLS must be an integer multiple of LANES");
    end

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          order_q, order_n, order_cur;
    logic          err_q, err_n;
    logic          accept, final_beat;
    frame_t        out_q, store, merged;

    assign accept     = bus.in_valid && bus.in_ready;
    assign final_beat = (cnt == CW'(BEATS - 1));
    // Beat 0 uses the live row_fast so the order it latches also applies to itself.
    assign order_cur  = (cnt == '0) ? bus.row_fast : order_q;

    always_comb begin : p_merge
        int unsigned          e;
        logic [BIT_WIDTH-1:0] lane;
        merged = store;
        e      = 0;
        lane   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            e    = 32'(cnt) * LANES + l;
            lane = BIT_WIDTH'(bus.in_data >> (l * BIT_WIDTH));
            if (order_cur)
                merged[RW'(e % ROWS)][KW'(e / ROWS)] = lane;
            else
                merged[RW'(e / COLS)][KW'(e % COLS)] = lane;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    frame_t asm_q;
    logic   out_valid_q, out_free, load_new, load_asm;

    assign store         = asm_q;
    assign bus.out_valid = out_valid_q;
`else
    assign store         = out_q;
    assign bus.out_valid = (state == HOLD);
`endif

    assign bus.out      = out_q;
    assign bus.in_ready = (state == FILL);
    assign bus.err      = err_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        order_n = order_q;
        err_n   = 1'b0;
`ifdef DOUBLE_BUFFER_EN
        out_free = !out_valid_q || bus.out_ready;
        load_new = 1'b0;
        load_asm = 1'b0;
`endif
        if (accept) begin
            if (cnt == '0)
                order_n = bus.row_fast;
            if (final_beat) begin
                cnt_n = '0;
                err_n = !bus.in_last;
            end else if (bus.in_last) begin
                cnt_n = '0;
                err_n = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
`ifdef DOUBLE_BUFFER_EN
        // HOLD here means a finished frame is parked in assembly waiting for out to free up.
        if (accept && final_beat) begin
            if (out_free) load_new = 1'b1;
            else          state_n  = HOLD;
        end
        if (state == HOLD && out_free) begin
            load_asm = 1'b1;
            state_n  = FILL;
        end
`else
        if (accept && final_beat)
            state_n = HOLD;
        if (state == HOLD && bus.out_ready)
            state_n = FILL;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            cnt     <= '0;
            order_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            order_q <= order_n;
            err_q   <= err_n;
        end
    end

`ifdef DOUBLE_BUFFER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept)
                asm_q <= merged;
            if (load_new)
                out_q <= merged;
            else if (load_asm)
                out_q <= asm_q;
            if (load_new || load_asm)
                out_valid_q <= 1'b1;
            else if (bus.out_ready)
                out_valid_q <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_q <= '0;
        else if (accept)
            out_q <= merged;
    end
`endif

endmodule

// File: tb/tb_stream_to_3d_array_buffer.sv
// Directed self-checking bench for stream_to_3d_array_buffer at default parameters (8x8x4, 2 lanes).
module tb_stream_to_3d_array_buffer;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   bad;
    int   hold_cycles;
    logic [255:0] prev;

    stream_to_3d_array_buffer_if #(.BIT_WIDTH(4), .ROWS(8), .COLS(8), .LANES(2)) bus ();

    stream_to_3d_array_buffer #(.BIT_WIDTH(4), .ROWS(8), .COLS(8), .LANES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_frame(input logic rf);
        logic [7:0][7:0][3:0] f;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                f[i][j] = rf ? 4'((j * 8 + i) % 16) : 4'((i * 8 + j) % 16);
        return f;
    endfunction

    // Drives beats first..last of a frame (element e carries e mod 16); returns on the negedge after the last accept.
    task automatic send_range(input int first, input int last, input int last_at,
                              input logic rf0, input logic rfr);
        int n;
        for (int b = first; b <= last; b++) begin
            bus.in_data  = {4'((b * 2 + 1) % 16), 4'((b * 2) % 16)};
            bus.in_valid = 1'b1;
            bus.in_last  = (b == last_at);
            bus.row_fast = (b == 0) ? rf0 : rfr;
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (bus.in_ready !== 1'b1)
                check("in_ready_timeout", bus.in_ready, 1);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.row_fast  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out", bus.out, '0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_err", bus.err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame in legacy order, completion latency and single-cycle out_valid
        send_range(0, 30, 31, 1'b1, 1'b1);
        check("a_valid_early", bus.out_valid, 0);
        send_range(31, 31, 31, 1'b1, 1'b1);
        check("a_valid", bus.out_valid, 1);
        check("a_err", bus.err, 0);
        check("a_out", bus.out, exp_frame(1'b1));
        @(negedge clk);
        check("a_valid_drop", bus.out_valid, 0);

        // Row-major order with row_fast toggled after beat 0
        send_range(0, 31, 31, 1'b0, 1'b1);
        check("b_valid", bus.out_valid, 1);
        check("b_out", bus.out, exp_frame(1'b0));
        @(negedge clk);

        // Abort on beat 5, then a clean frame
        send_range(0, 5, 5, 1'b1, 1'b1);
        check("abort_err", bus.err, 1);
        check("abort_valid", bus.out_valid, 0);
        @(negedge clk);
        check("abort_err_clear", bus.err, 0);
        check("abort_valid_still0", bus.out_valid, 0);
        send_range(0, 31, 31, 1'b1, 1'b1);
        check("post_abort_valid", bus.out_valid, 1);
        check("post_abort_out", bus.out, exp_frame(1'b1));
        @(negedge clk);

        // Final beat without in_last
        send_range(0, 31, -1, 1'b0, 1'b0);
        check("nolast_valid", bus.out_valid, 1);
        check("nolast_err", bus.err, 1);
        check("nolast_out", bus.out, exp_frame(1'b0));
        @(negedge clk);
        check("nolast_err_clear", bus.err, 0);

        // Back-pressure: frame held while out_ready is low
        bus.out_ready = 1'b0;
        send_range(0, 31, 31, 1'b1, 1'b1);
        check("hold_valid", bus.out_valid, 1);
        check("hold_out", bus.out, exp_frame(1'b1));
`ifdef DOUBLE_BUFFER_EN
        check("hold_ready_db_open", bus.in_ready, 1);
        send_range(0, 31, 31, 1'b0, 1'b0);
        check("hold_ready_db_closed", bus.in_ready, 0);
        hold_cycles = 18;
`else
        check("hold_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = '1;
        hold_cycles  = 50;
`endif
        prev = bus.out;
        bad  = 0;
        repeat (hold_cycles) begin
            @(negedge clk);
            if (bus.out !== prev || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                bad++;
        end
        check("hold_stable_cycles_bad", 32'(bad), 0);
        check("hold_out_end", bus.out, exp_frame(1'b1));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
`ifdef DOUBLE_BUFFER_EN
        check("release_db_valid", bus.out_valid, 1);
        check("release_db_out", bus.out, exp_frame(1'b0));
        check("release_db_ready", bus.in_ready, 1);
        @(negedge clk);
        check("release_db_valid_drop", bus.out_valid, 0);
`else
        check("release_valid", bus.out_valid, 0);
        check("release_ready", bus.in_ready, 1);
`endif

        // Asynchronous reset during beat 17
        send_range(0, 16, 31, 1'b1, 1'b1);
        bus.in_data  = 8'h23;
        bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out", bus.out, '0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_err", bus.err, 0);
        check("arst_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        send_range(0, 31, 31, 1'b0, 1'b0);
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_out", bus.out, exp_frame(1'b0));
        check("post_rst_err", bus.err, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
